fpu_wb_regif: RTL and testbench

//  Wishbone slave register file between the Caravel user-project bus and the FPU core.

---
 rtl/fpu_wb_regif_pkg.sv | 38 +++
 rtl/fpu_wb_regif_if.sv | 28 ++
 rtl/fpu_wb_regif.sv | 196 +++++++++++++++++++
 tb/tb_fpu_wb_regif.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_wb_regif_pkg.sv
// Package for the FPU wishbone register interface.
// Holds the register offsets, STATUS bit positions, the GO bit index and the
// rounding-mode width, plus a byte-lane merge helper used by every rw register.
package fpu_regif_pkg;

  // Word-aligned byte offsets within the block.
  localparam logic [7:0] OffA      = 8'h00;
  localparam logic [7:0] OffB      = 8'h04;
  localparam logic [7:0] OffC      = 8'h08;
  localparam logic [7:0] OffResult = 8'h0C;
  localparam logic [7:0] OffFlags  = 8'h10;
  localparam logic [7:0] OffStatus = 8'h14;
  localparam logic [7:0] OffOp     = 8'h1C;
  localparam logic [7:0] OffRm     = 8'h24;

  // STATUS bit positions.
  localparam int unsigned StBusyBit = 0;
  localparam int unsigned StDoneBit = 1;
  localparam int unsigned StErrBit  = 2;
  localparam int unsigned StIeBit   = 8;

  // OP register launch bit and rounding-mode field width.
  localparam int unsigned GoBit = 13;
  localparam int unsigned RmW   = 3;

  // Replace only the byte lanes selected by sel.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/fpu_wb_regif_if.sv
// Wishbone classic slave bus bundle for the FPU register interface.
// Signals keep the Caravel user-project names (direction seen from the slave).
//   wbs_cyc_i, wbs_stb_i, wbs_we_i : cycle, strobe, write enable
//   wbs_sel_i [3:0]                : byte lane select
//   wbs_adr_i [31:0]               : byte address
//   wbs_dat_i [31:0]               : write data
//   wbs_ack_o                      : acknowledge
//   wbs_dat_o [31:0]               : read data
interface fpu_wb_regif_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/fpu_wb_regif.sv
// Wishbone slave register file in front of the FPU core.
// Decodes bus writes into operand / rounding-mode / operation registers, fires a
// one-cycle valid_in launch on a GO write, captures result and flags on
// fpu_valid_out_i and exposes busy/done/err status for polling.
// Optional feature macro: FPU_IRQ_EN enables the ie bit, done write-1-to-clear
// and the registered irq_o = done & ie. Without it irq_o is held at 0.
// Ports:
//   clk, rst_l          clock, asynchronous active-low reset
//   wb                  wishbone slave bundle (fpu_wb_regif_if.slave)
//   a_o, b_o, c_o       FPU operands
//   round_mode_o        FPU rounding mode
//   op_in_o             FPU operation field
//   valid_in_o          one-cycle launch pulse
//   fpu_result_i        FPU result
//   fpu_flags_i         FPU exception flags
//   fpu_valid_out_i     FPU result valid, single cycle
//   irq_o               done interrupt
module fpu_wb_regif
  import fpu_regif_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned OP_W      = 13,
  parameter int unsigned FLAG_W    = 5
) (
  input  logic              clk,
  input  logic              rst_l,
  fpu_wb_regif_if.slave     wb,
  output logic [31:0]       a_o,
  output logic [31:0]       b_o,
  output logic [31:0]       c_o,
  output logic [RmW-1:0]    round_mode_o,
  output logic [OP_W-1:0]   op_in_o,
  output logic              valid_in_o,
  input  logic [31:0]       fpu_result_i,
  input  logic [FLAG_W-1:0] fpu_flags_i,
  input  logic              fpu_valid_out_i,
  output logic              irq_o
);

  logic [31:0]       a_q, a_d, b_q, b_d, c_q, c_d;
  logic [31:0]       res_q, res_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [RmW-1:0]    rm_q, rm_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, ie_q, ie_d;
  logic              valid_q, valid_d, irq_q, irq_d;
  logic              ack_q;
  logic [31:0]       dat_q, rdata;

  logic       req, hit, wr, go, go_ok;
  logic [7:0] off;
  logic [31:0] status_w, op_merged, rm_merged;
  logic       unused_adr;

  // Word offset only; the two byte-address LSBs do not take part in decode.
  assign unused_adr = ^wb.wbs_adr_i[1:0];

  // One ack per request: the cycle after ack never re-triggers even if stb stays high.
  assign req = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q;
  assign hit = (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign off = {wb.wbs_adr_i[7:2], 2'b00};
  assign wr  = req & wb.wbs_we_i & hit;

  always_comb begin
    status_w            = '0;
    status_w[StBusyBit] = busy_q;
    status_w[StDoneBit] = done_q;
    status_w[StErrBit]  = err_q;
    status_w[StIeBit]   = ie_q;
  end

  // Read mux; OP is write-only and unmapped offsets read 0.
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        OffA:      rdata = a_q;
        OffB:      rdata = b_q;
        OffC:      rdata = c_q;
        OffResult: rdata = res_q;
        OffFlags:  rdata = 32'(flags_q);
        OffStatus: rdata = status_w;
        OffRm:     rdata = 32'(rm_q);
        default:   rdata = '0;
      endcase
    end
  end

  assign op_merged = merge_bytes(32'(op_q), wb.wbs_dat_i, wb.wbs_sel_i);
  assign rm_merged = merge_bytes(32'(rm_q), wb.wbs_dat_i, wb.wbs_sel_i);

  assign go    = wr && (off == OffOp) && wb.wbs_sel_i[1] && wb.wbs_dat_i[GoBit];
  // A completing result frees the FPU in the same cycle, so a go is accepted then too.
  assign go_ok = go && (!busy_q || fpu_valid_out_i);

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    flags_d = flags_q;
    op_d    = op_q;
    rm_d    = rm_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    ie_d    = ie_q;
    valid_d = 1'b0;
    irq_d   = 1'b0;

    if (wr) begin
      case (off)
        OffA:  a_d  = merge_bytes(a_q, wb.wbs_dat_i, wb.wbs_sel_i);
        OffB:  b_d  = merge_bytes(b_q, wb.wbs_dat_i, wb.wbs_sel_i);
        OffC:  c_d  = merge_bytes(c_q, wb.wbs_dat_i, wb.wbs_sel_i);
        OffOp: op_d = op_merged[OP_W-1:0];
        OffRm: rm_d = rm_merged[RmW-1:0];
        OffStatus: begin
          if (wb.wbs_sel_i[0] && wb.wbs_dat_i[StErrBit]) err_d = 1'b0;
`ifdef FPU_IRQ_EN
          if (wb.wbs_sel_i[0] && wb.wbs_dat_i[StDoneBit]) done_d = 1'b0;
          if (wb.wbs_sel_i[1]) ie_d = wb.wbs_dat_i[StIeBit];
`endif
        end
        default: ;
      endcase
    end

    // Completion is applied before the launch so an accepted go wins on busy/done.
    if (fpu_valid_out_i) begin
      res_d   = fpu_result_i;
      flags_d = fpu_flags_i;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end

    if (go_ok) begin
      valid_d = 1'b1;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else if (go) begin
      err_d = 1'b1;
    end

`ifdef FPU_IRQ_EN
    irq_d = done_d & ie_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
      op_q    <= '0;
      rm_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ie_q    <= 1'b0;
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      op_q    <= op_d;
      rm_q    <= rm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ie_q    <= ie_d;
      valid_q <= valid_d;
      irq_q   <= irq_d;
      ack_q   <= req;
      if (req) dat_q <= rdata;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign a_o          = a_q;
  assign b_o          = b_q;
  assign c_o          = c_q;
  assign round_mode_o = rm_q;
  assign op_in_o      = op_q;
  assign valid_in_o   = valid_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_fpu_wb_regif.sv
// Self-checking bench for fpu_wb_regif: transaction-level register model plus
// literal expectations for the directed scenarios. Honours FPU_IRQ_EN.
module tb_fpu_wb_regif;

  localparam logic [31:0] Base    = 32'h3000_0000;
  localparam logic [31:0] AdrA    = Base + 32'h00;
  localparam logic [31:0] AdrB    = Base + 32'h04;
  localparam logic [31:0] AdrC    = Base + 32'h08;
  localparam logic [31:0] AdrRes  = Base + 32'h0C;
  localparam logic [31:0] AdrFlg  = Base + 32'h10;
  localparam logic [31:0] AdrStat = Base + 32'h14;
  localparam logic [31:0] AdrOp   = Base + 32'h1C;
  localparam logic [31:0] AdrRm   = Base + 32'h24;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [31:0] a_o, b_o, c_o;
  logic [2:0]  round_mode_o;
  logic [12:0] op_in_o;
  logic        valid_in_o, irq_o;
  logic [31:0] fpu_result_i = '0;
  logic [4:0]  fpu_flags_i = '0;
  logic        fpu_valid_out_i = 1'b0;

  fpu_wb_regif_if wb ();

  fpu_wb_regif dut (
    .clk             (clk),
    .rst_l           (rst_l),
    .wb              (wb),
    .a_o             (a_o),
    .b_o             (b_o),
    .c_o             (c_o),
    .round_mode_o    (round_mode_o),
    .op_in_o         (op_in_o),
    .valid_in_o      (valid_in_o),
    .fpu_result_i    (fpu_result_i),
    .fpu_flags_i     (fpu_flags_i),
    .fpu_valid_out_i (fpu_valid_out_i),
    .irq_o           (irq_o)
  );

  always #5 clk = ~clk;

  // Register model.
  logic [31:0] m_a, m_b, m_c, m_res;
  logic [4:0]  m_flags;
  logic [12:0] m_op;
  logic [2:0]  m_rm;
  logic        m_busy, m_done, m_err, m_ie;
  logic        exp_ack, exp_valid;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (sel[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction

  function automatic logic exp_irq();
`ifdef FPU_IRQ_EN
    return m_done & m_ie;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] adr);
    if (adr[31:8] != Base[31:8]) return 32'h0;
    case ({adr[7:2], 2'b00})
      8'h00:   return m_a;
      8'h04:   return m_b;
      8'h08:   return m_c;
      8'h0C:   return m_res;
      8'h10:   return {27'h0, m_flags};
      8'h14:   return {23'h0, m_ie, 5'h0, m_err, m_done, m_busy};
      8'h24:   return {29'h0, m_rm};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_a = '0; m_b = '0; m_c = '0; m_res = '0; m_flags = '0; m_op = '0; m_rm = '0;
    m_busy = 0; m_done = 0; m_err = 0; m_ie = 0; exp_ack = 0; exp_valid = 0;
  endtask

  // One bus transaction, optionally with an FPU completion in the commit cycle.
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic vo, input logic [31:0] res,
                     input logic [4:0] flg, output logic [31:0] rd);
    logic [31:0] exp_rd, tmp;
    logic [7:0]  off;
    logic        hit, go, was_busy;
    @(negedge clk);
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = we;
    wb.wbs_adr_i = adr; wb.wbs_dat_i = dat; wb.wbs_sel_i = sel;
    if (vo) begin
      fpu_valid_out_i = 1; fpu_result_i = res; fpu_flags_i = flg;
    end
    @(posedge clk); #1;
    exp_rd   = m_read(adr);
    hit      = (adr[31:8] == Base[31:8]);
    off      = {adr[7:2], 2'b00};
    was_busy = m_busy;
    go       = we && hit && off == 8'h1C && sel[1] && dat[13];
    if (we && hit) begin
      case (off)
        8'h00: m_a = merge(m_a, dat, sel);
        8'h04: m_b = merge(m_b, dat, sel);
        8'h08: m_c = merge(m_c, dat, sel);
        8'h1C: begin tmp = merge({19'h0, m_op}, dat, sel); m_op = tmp[12:0]; end
        8'h24: begin tmp = merge({29'h0, m_rm}, dat, sel); m_rm = tmp[2:0]; end
        8'h14: begin
          if (sel[0] && dat[2]) m_err = 0;
`ifdef FPU_IRQ_EN
          if (sel[0] && dat[1]) m_done = 0;
          if (sel[1]) m_ie = dat[8];
`endif
        end
        default: ;
      endcase
    end
    if (vo) begin
      m_res = res; m_flags = flg; m_busy = 0; m_done = 1;
    end
    if (go) begin
      if (!was_busy || vo) begin
        exp_valid = 1; m_busy = 1; m_done = 0;
      end else begin
        m_err = 1;
      end
    end
    exp_ack = 1;
    fpu_valid_out_i = 0;
    @(negedge clk);
    rd = wb.wbs_dat_o;
    if (!we) chk("rdata", rd, exp_rd);
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    @(posedge clk); #1;
    exp_ack = 0; exp_valid = 0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d;
    bus(1'b1, adr, dat, sel, 1'b0, 32'h0, 5'h0, d);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d);
    bus(1'b0, adr, 32'h0, 4'h0, 1'b0, 32'h0, 5'h0, d);
  endtask

  task automatic fpu_pulse(input logic [31:0] res, input logic [4:0] flg);
    @(negedge clk);
    fpu_valid_out_i = 1; fpu_result_i = res; fpu_flags_i = flg;
    @(posedge clk); #1;
    m_res = res; m_flags = flg; m_busy = 0; m_done = 1;
    fpu_valid_out_i = 0;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_o", a_o, m_a);
      chk("b_o", b_o, m_b);
      chk("c_o", c_o, m_c);
      chk("round_mode_o", 32'(round_mode_o), 32'(m_rm));
      chk("op_in_o", 32'(op_in_o), 32'(m_op));
      chk("valid_in_o", 32'(valid_in_o), 32'(exp_valid));
      chk("ack", 32'(wb.wbs_ack_o), 32'(exp_ack));
      chk("irq_o", 32'(irq_o), 32'(exp_irq()));
    end
  end

  always @(negedge clk) if (valid_in_o) pulses++;

  initial begin
    logic [31:0] d;
    int p0;
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    wb.wbs_sel_i = '0; wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_l = 1;
    chk_en = 1;

    // Reset state.
    rd(AdrStat, d); chk("reset_status", d, 32'h0);
    rd(AdrA, d);    chk("reset_a", d, 32'h0);

    // Full-word write and readback.
    wr(AdrA, 32'h3F80_0000, 4'hF);
    chk("t1_a_o", a_o, 32'h3F80_0000);
    rd(AdrA, d); chk("t1_readback", d, 32'h3F80_0000);

    // Byte lanes.
    wr(AdrA, 32'h0, 4'hF);
    wr(AdrA, 32'hFFFF_FFFF, 4'b0101);
    chk("t2_a_o", a_o, 32'h00FF_00FF);
    wr(AdrB, 32'h1234_5678, 4'hF);
    wr(AdrC, 32'hAABB_CCDD, 4'b0011);
    chk("c_lanes", c_o, 32'h0000_CCDD);

    // Unmapped offset and foreign base: acked, ignored, read 0.
    wr(Base + 32'h20, 32'hDEAD_BEEF, 4'hF);
    rd(Base + 32'h20, d); chk("unmapped_rd", d, 32'h0);
    wr(32'h3000_0100, 32'h1111_1111, 4'hF);
    chk("foreign_base", a_o, 32'h00FF_00FF);

    // Launch.
    wr(AdrRm, 32'h2, 4'h1);
    chk("t3_rm", 32'(round_mode_o), 32'h2);
    p0 = pulses;
    wr(AdrOp, 32'h0000_2010, 4'hF);
    chk("t3_op", 32'(op_in_o), 32'h0010);
    chk("t3_pulses", pulses - p0, 1);
    rd(AdrStat, d); chk("t3_status", d, 32'h1);
    rd(AdrOp, d);   chk("op_reads_0", d, 32'h0);
    rd(AdrRm, d);   chk("rm_rd", d, 32'h2);

    // Completion.
    fpu_pulse(32'h4000_0000, 5'h01);
    rd(AdrRes, d);  chk("t4_result", d, 32'h4000_0000);
    rd(AdrFlg, d);  chk("t4_flags", d, 32'h1);
    rd(AdrStat, d); chk("t4_status", d, 32'h2);

    // Go accepted, then go while busy is dropped with err.
    p0 = pulses;
    wr(AdrOp, 32'h0000_2105, 4'b0011);
    chk("t5_go_pulse", pulses - p0, 1);
    chk("t5_op", 32'(op_in_o), 32'h0105);
    p0 = pulses;
    wr(AdrOp, 32'h0000_2077, 4'hF);
    chk("t5_busy_nopulse", pulses - p0, 0);
    chk("t5_op_dropped", 32'(op_in_o), 32'h0077);
    rd(AdrStat, d); chk("t5_err", d, 32'h5);
    wr(AdrStat, 32'h4, 4'h1);
    rd(AdrStat, d); chk("t5_err_clr", d, 32'h1);
    p0 = pulses;
    bus(1'b1, AdrOp, 32'h0000_2033, 4'hF, 1'b1, 32'hC000_0000, 5'h10, d);
    chk("t5_coinc_pulse", pulses - p0, 1);
    rd(AdrStat, d); chk("t5_coinc_status", d, 32'h1);
    rd(AdrRes, d);  chk("t5_coinc_result", d, 32'hC000_0000);
    rd(AdrFlg, d);  chk("t5_coinc_flags", d, 32'h10);

    // Interrupt / ie behaviour.
    fpu_pulse(32'h4040_0000, 5'h00);
    wr(AdrStat, 32'h100, 4'b0010);
`ifdef FPU_IRQ_EN
    chk("irq_set", 32'(irq_o), 32'h1);
    rd(AdrStat, d); chk("ie_status", d, 32'h102);
    wr(AdrStat, 32'h2, 4'h1);
    chk("irq_clr", 32'(irq_o), 32'h0);
    rd(AdrStat, d); chk("done_w1c", d, 32'h100);
`else
    chk("irq_tied", 32'(irq_o), 32'h0);
    rd(AdrStat, d); chk("ie_reads_0", d, 32'h2);
    wr(AdrStat, 32'h2, 4'h1);
    rd(AdrStat, d); chk("done_no_w1c", d, 32'h2);
`endif

    // Asynchronous reset mid-operation.
    wr(AdrOp, 32'h0000_2001, 4'hF);
    @(posedge clk); #2;
    chk_en = 0;
    rst_l = 0;
    #1;
    chk("rst_a", a_o, 32'h0);
    chk("rst_b", b_o, 32'h0);
    chk("rst_c", c_o, 32'h0);
    chk("rst_rm", 32'(round_mode_o), 32'h0);
    chk("rst_op", 32'(op_in_o), 32'h0);
    chk("rst_valid", 32'(valid_in_o), 32'h0);
    chk("rst_ack", 32'(wb.wbs_ack_o), 32'h0);
    chk("rst_dat", wb.wbs_dat_o, 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    model_reset();
    @(negedge clk);
    rst_l = 1;
    chk_en = 1;
    rd(AdrStat, d); chk("post_rst_status", d, 32'h0);
    fpu_pulse(32'h3F00_0000, 5'h02);
    rd(AdrStat, d); chk("idle_capture_status", d, 32'h2);
    rd(AdrRes, d);  chk("idle_capture_result", d, 32'h3F00_0000);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
